// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Latency: n/a; backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int MEMLAT_MIN = 1;
  localparam int MEMLAT_MAX = 7;
  localparam int CNTW       = 3;

endpackage

// File: rtl/mem_arbiter_rr.sv
// 2-way round-robin picker: the port not granted last wins a tie.
// Latency: combinational; backpressure: none, the caller holds the pointer.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       win
);

  always_comb begin
    win = PORT_CPU;
    if (req[PORT_CPU] && req[PORT_DBG]) win = ~last;
    else if (req[PORT_DBG])            win = PORT_DBG;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes core and debug req/ack masters onto one synchronous-read memory.
// Latency: write acks in cycle 2, read in cycle 2+MEMLAT; losers wait for the access plus one IDLE cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADRW   = 32,
  parameter int MEMLAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [ADRW-1:0]  cpu_adr,
  input  logic [WIDTH-1:0] cpu_wd,
  output logic [WIDTH-1:0] cpu_rd,
  output logic             cpu_ack,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [ADRW-1:0]  dbg_adr,
  input  logic [WIDTH-1:0] dbg_wd,
  output logic [WIDTH-1:0] dbg_rd,
  output logic             dbg_ack,
  output logic [ADRW-1:0]  mem_adr,
  output logic [WIDTH-1:0] mem_wd,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic             owner
);

  if (MEMLAT < MEMLAT_MIN || MEMLAT > MEMLAT_MAX) begin : g_bad_memlat
    $error("mem_arbiter: MEMLAT out of range 1..7");
  end

  state_t          state;
  logic            ptr;
  logic [CNTW-1:0] cnt;
  logic            win;

  rr_arb2 u_rr (
    .req  ({dbg_req, cpu_req}),
    .last (ptr),
    .win  (win)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= PORT_DBG;
      cnt     <= '0;
      owner   <= PORT_CPU;
      busy    <= 1'b0;
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      mem_we  <= 1'b0;
      mem_adr <= '0;
      mem_wd  <= '0;
      cpu_rd  <= '0;
      dbg_rd  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            owner   <= win;
            mem_adr <= (win == PORT_DBG) ? dbg_adr : cpu_adr;
            mem_wd  <= (win == PORT_DBG) ? dbg_wd  : cpu_wd;
            mem_we  <= (win == PORT_DBG) ? dbg_we  : cpu_we;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          // mem_we doubles as the latched write flag for the granted access
          if (mem_we) begin
            if (owner == PORT_DBG) dbg_ack <= 1'b1;
            else                   cpu_ack <= 1'b1;
            state <= ACK;
          end else begin
            cnt   <= CNTW'(MEMLAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNTW'(1)) begin
            if (owner == PORT_DBG) begin
              dbg_rd  <= mem_rdata;
              dbg_ack <= 1'b1;
            end else begin
              cpu_rd  <= mem_rdata;
              cpu_ack <= 1'b1;
            end
            state <= ACK;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        ACK: begin
          ptr   <= owner;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances at MEMLAT 1/3/7, each with a
// registered-read memory model whose pipeline depth equals that instance's MEMLAT.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;

  logic        cpu_req [3];
  logic        cpu_we  [3];
  logic [31:0] cpu_adr [3];
  logic [31:0] cpu_wd  [3];
  logic [31:0] cpu_rd  [3];
  logic        cpu_ack [3];
  logic        dbg_req [3];
  logic        dbg_we  [3];
  logic [31:0] dbg_adr [3];
  logic [31:0] dbg_wd  [3];
  logic [31:0] dbg_rd  [3];
  logic        dbg_ack [3];
  logic [31:0] mem_adr [3];
  logic [31:0] mem_wd  [3];
  logic        mem_we  [3];
  logic [31:0] mem_rdata [3];
  logic        busy    [3];
  logic        owner   [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 7);
    logic [31:0] mem  [64];
    logic [31:0] pipe [8];

    mem_arbiter #(.WIDTH(32), .ADRW(32), .MEMLAT(LAT)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req[g]),
      .cpu_we    (cpu_we[g]),
      .cpu_adr   (cpu_adr[g]),
      .cpu_wd    (cpu_wd[g]),
      .cpu_rd    (cpu_rd[g]),
      .cpu_ack   (cpu_ack[g]),
      .dbg_req   (dbg_req[g]),
      .dbg_we    (dbg_we[g]),
      .dbg_adr   (dbg_adr[g]),
      .dbg_wd    (dbg_wd[g]),
      .dbg_rd    (dbg_rd[g]),
      .dbg_ack   (dbg_ack[g]),
      .mem_adr   (mem_adr[g]),
      .mem_wd    (mem_wd[g]),
      .mem_we    (mem_we[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g]),
      .owner     (owner[g])
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        mem[16] <= 32'hDEADBEEF;
        mem[8]  <= 32'hCAFEF00D;
        for (int k = 0; k < 8; k++) pipe[k] <= 32'h0;
      end else begin
        if (mem_we[g]) mem[mem_adr[g][7:2]] <= mem_wd[g];
        pipe[0] <= mem[mem_adr[g][7:2]];
        for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
      end
    end

    assign mem_rdata[g] = pipe[LAT-1];
  end

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (g_inst[0].u_dut.state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d want %0d", g_inst[0].u_dut.state, IDLE); end
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy[0]); end
    tests++; if (owner[0] !== 1'b0) begin fails++; $display("FAIL reset_owner: got %b want 0", owner[0]); end
    tests++; if (mem_we[0] !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b want 0", mem_we[0]); end
    tests++; if (mem_adr[0] !== 32'h0) begin fails++; $display("FAIL reset_mem_adr: got %h want 0", mem_adr[0]); end
    tests++; if (cpu_rd[0] !== 32'h0) begin fails++; $display("FAIL reset_cpu_rd: got %h want 0", cpu_rd[0]); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL idle_no_req_busy: got %b want 0", busy[0]); end
  endtask

  task automatic test_core_read;
    int          ack_c = -1;
    bit          dbg_seen = 0;
    logic [31:0] adr1 = '0;
    logic        we1 = 1'b0;
    logic        ack_after, busy_after;
    @(negedge clk);
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_adr[0] = 32'h40; cpu_wd[0] = 32'h55;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin adr1 = mem_adr[0]; we1 = mem_we[0]; end
      if (dbg_ack[0]) dbg_seen = 1;
      if (cpu_ack[0]) begin ack_c = c; cpu_req[0] = 1'b0; break; end
    end
    cpu_req[0] = 1'b0;
    @(negedge clk);
    ack_after = cpu_ack[0]; busy_after = busy[0];
    tests++; if (adr1 !== 32'h40) begin fails++; $display("FAIL rd_mem_adr_c1: got %h want 00000040", adr1); end
    tests++; if (we1 !== 1'b0) begin fails++; $display("FAIL rd_mem_we_c1: got %b want 0", we1); end
    tests++; if (ack_c != 3) begin fails++; $display("FAIL rd_ack_cycle: got %0d want 3", ack_c); end
    tests++; if (cpu_rd[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_cpu_rd: got %h want deadbeef", cpu_rd[0]); end
    tests++; if (dbg_seen !== 1'b0) begin fails++; $display("FAIL rd_dbg_ack_quiet: got %b want 0", dbg_seen); end
    tests++; if (ack_after !== 1'b0) begin fails++; $display("FAIL rd_ack_one_cycle: got %b want 0", ack_after); end
    tests++; if (busy_after !== 1'b0) begin fails++; $display("FAIL rd_busy_after: got %b want 0", busy_after); end
  endtask

  task automatic test_dbg_write;
    int          ack_c = -1;
    int          nack = 0;
    logic [31:0] we_mask = '0;
    @(negedge clk);
    dbg_req[0] = 1'b1; dbg_we[0] = 1'b1; dbg_adr[0] = 32'h80; dbg_wd[0] = 32'h12345678;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_we[0]) we_mask[c] = 1'b1;
      if (dbg_ack[0]) begin nack++; if (ack_c < 0) ack_c = c; dbg_req[0] = 1'b0; end
    end
    dbg_req[0] = 1'b0;
    tests++; if (ack_c != 2) begin fails++; $display("FAIL wr_ack_cycle: got %0d want 2", ack_c); end
    tests++; if (nack != 1) begin fails++; $display("FAIL wr_ack_count: got %0d want 1", nack); end
    tests++; if (we_mask !== 32'h2) begin fails++; $display("FAIL wr_mem_we_cycles: got %h want 00000002", we_mask); end
    tests++; if (g_inst[0].mem[32] !== 32'h12345678) begin fails++; $display("FAIL wr_mem_word: got %h want 12345678", g_inst[0].mem[32]); end
    tests++; if (cpu_rd[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_cpu_rd_kept: got %h want deadbeef", cpu_rd[0]); end
    tests++; if (dbg_rd[0] !== 32'h0) begin fails++; $display("FAIL wr_dbg_rd_kept: got %h want 0", dbg_rd[0]); end
  endtask

  task automatic test_simultaneous;
    int   cpu_c0 = -1, cpu_c1 = -1, dbg_c = -1, ncpu = 0;
    logic own1 = 1'bx, own5 = 1'bx;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_adr[0] = 32'h40;
    dbg_req[0] = 1'b1; dbg_we[0] = 1'b0; dbg_adr[0] = 32'h20;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 1) own1 = owner[0];
      if (c == 5) own5 = owner[0];
      if (cpu_ack[0]) begin
        if (ncpu == 0) cpu_c0 = c; else if (ncpu == 1) cpu_c1 = c;
        ncpu++;
        if (ncpu >= 2) cpu_req[0] = 1'b0;
      end
      if (dbg_ack[0]) begin dbg_c = c; dbg_req[0] = 1'b0; end
      if (ncpu >= 2 && dbg_c >= 0) break;
    end
    cpu_req[0] = 1'b0; dbg_req[0] = 1'b0;
    tests++; if (own1 !== 1'b0) begin fails++; $display("FAIL tie_first_owner: got %b want 0", own1); end
    tests++; if (cpu_c0 != 3) begin fails++; $display("FAIL tie_cpu_ack: got %0d want 3", cpu_c0); end
    tests++; if (own5 !== 1'b1) begin fails++; $display("FAIL tie_repeat_owner: got %b want 1", own5); end
    tests++; if (dbg_c != 7) begin fails++; $display("FAIL tie_dbg_ack: got %0d want 7", dbg_c); end
    tests++; if (cpu_c1 != 11) begin fails++; $display("FAIL tie_cpu_second_ack: got %0d want 11", cpu_c1); end
    tests++; if (dbg_rd[0] !== 32'hCAFEF00D) begin fails++; $display("FAIL tie_dbg_rd: got %h want cafef00d", dbg_rd[0]); end
    tests++; if (cpu_rd[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL tie_cpu_rd: got %h want deadbeef", cpu_rd[0]); end
  endtask

  task automatic test_latency_sweep;
    int ack_c [3] = '{-1, -1, -1};
    int exp_c [3] = '{3, 5, 9};
    bit adr_bad [3] = '{0, 0, 0};
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      cpu_req[g] = 1'b1; cpu_we[g] = 1'b0; cpu_adr[g] = 32'h40;
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (ack_c[g] < 0) begin
          if (mem_adr[g] !== 32'h40) adr_bad[g] = 1;
          if (cpu_ack[g]) begin ack_c[g] = c; cpu_req[g] = 1'b0; end
        end
      end
    end
    for (int g = 0; g < 3; g++) begin
      cpu_req[g] = 1'b0;
      tests++; if (ack_c[g] != exp_c[g]) begin fails++; $display("FAIL lat_ack_cycle[%0d]: got %0d want %0d", g, ack_c[g], exp_c[g]); end
      tests++; if (adr_bad[g] !== 1'b0) begin fails++; $display("FAIL lat_adr_stable[%0d]: got unstable=%b want 0", g, adr_bad[g]); end
      tests++; if (cpu_rd[g] !== 32'hDEADBEEF) begin fails++; $display("FAIL lat_cpu_rd[%0d]: got %h want deadbeef", g, cpu_rd[g]); end
    end
  endtask

  task automatic test_reset_mid;
    state_t st2;
    bit     ack_seen = 0;
    int     ack_c = -1;
    @(negedge clk);
    dbg_req[0] = 1'b1; dbg_we[0] = 1'b0; dbg_adr[0] = 32'h20;
    repeat (2) @(negedge clk);
    st2 = g_inst[0].u_dut.state;
    reset = 1'b1; dbg_req[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tests++; if (st2 !== WAIT) begin fails++; $display("FAIL mid_was_wait: got %0d want %0d", st2, WAIT); end
    tests++; if (g_inst[0].u_dut.state !== IDLE) begin fails++; $display("FAIL mid_state: got %0d want %0d", g_inst[0].u_dut.state, IDLE); end
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", busy[0]); end
    tests++; if (mem_we[0] !== 1'b0) begin fails++; $display("FAIL mid_mem_we: got %b want 0", mem_we[0]); end
    tests++; if (dbg_rd[0] !== 32'h0) begin fails++; $display("FAIL mid_dbg_rd: got %h want 0", dbg_rd[0]); end
    for (int c = 0; c < 6; c++) begin
      if (dbg_ack[0]) ack_seen = 1;
      @(negedge clk);
    end
    tests++; if (ack_seen !== 1'b0) begin fails++; $display("FAIL mid_no_dbg_ack: got %b want 0", ack_seen); end
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_adr[0] = 32'h40;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (cpu_ack[0]) begin ack_c = c; cpu_req[0] = 1'b0; break; end
    end
    cpu_req[0] = 1'b0;
    tests++; if (ack_c != 3) begin fails++; $display("FAIL mid_after_ack: got %0d want 3", ack_c); end
    tests++; if (cpu_rd[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL mid_after_rd: got %h want deadbeef", cpu_rd[0]); end
  endtask

  initial begin
    reset = 1'b1;
    for (int g = 0; g < 3; g++) begin
      cpu_req[g] = 1'b0; cpu_we[g] = 1'b0; cpu_adr[g] = '0; cpu_wd[g] = '0;
      dbg_req[g] = 1'b0; dbg_we[g] = 1'b0; dbg_adr[g] = '0; dbg_wd[g] = '0;
    end
    test_reset();
    test_core_read();
    test_dbg_write();
    test_simultaneous();
    test_latency_sweep();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified instruction/data memory of the multicycle MIPS core between the core (port 0) and a debug/program-loader master (port 1). Each requester uses a req/ack handshake. The arbiter serializes accesses, drives the memory port, and handles a synchronous-read memory of configurable latency. It sits between the core's adr/writedata/memwrite/readdata bus and the memory instance in the top level.

## Interface
- `WIDTH`, 32, data width
- `ADRW`, 32, address width
- `MEMLAT`, 1, memory read latency in cycles (legal range 1..7)

Ports (name, direction, width, meaning):
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `cpu_req`  in  1  core request; held until `cpu_ack`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_adr`  in  ADRW  byte address
- `cpu_wd`  in  WIDTH  write data
- `cpu_rd`  out  WIDTH  read data, valid from `cpu_ack`
- `cpu_ack`  out  1  one-cycle completion pulse
- `dbg_req`, `dbg_we`, `dbg_adr`, `dbg_wd`, `dbg_rd`, `dbg_ack`: same as the `cpu_*` ports, for port 1
- `mem_adr`  out  ADRW  memory address
- `mem_wd`  out  WIDTH  memory write data
- `mem_we`  out  1  memory write strobe
- `mem_rdata`  in  WIDTH  memory read data, valid MEMLAT cycles after `mem_adr`
- `busy`  out  1  access in progress (any state other than IDLE)
- `owner`  out  1  port index of the current or last grant

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, ACK.
- **IDLE:**
  - No request pending: stay in IDLE.
  - Request pending: select the winner, latch its we/adr/wd, set `owner`, go to ISSUE.
- **Arbitration:** 2-way round-robin.
  - If only one port requests, that port wins.
  - If both request, the port not granted last wins.
  - After reset the last-grant pointer is 1, so the core wins the first tie.
- **ISSUE:** `mem_adr` and `mem_wd` are driven from the latched values; `mem_we` = latched we.
  - Write: go to ACK.
  - Read: load the wait counter with MEMLAT and go to WAIT.
- **WAIT:** `mem_adr` held; counter decrements each cycle.
  - When the counter reaches 1, capture `mem_rdata` into the owner's rd register and go to ACK.
- **ACK:** pulse the owner's ack for one cycle, update the round-robin pointer to owner, go to IDLE.
- **Write-port outputs:** `mem_we` is high only in ISSUE. `mem_adr` and `mem_wd` are registered and hold their last value outside an access.
- **Read data:** `cpu_rd` and `dbg_rd` hold their last captured value until the next read completes on that port. A write never changes them.
- **Protocol rules:**
  - A requester drops req in its ack cycle or later.
  - Because ACK returns to IDLE, a req still high when IDLE re-evaluates is a new access.
  - Deasserting req mid-access is illegal. The arbiter completes the access and still pulses ack.
- **Reset (including mid-access):**
  - state = IDLE; pointer = 1
  - all acks = 0, `mem_we` = 0, `busy` = 0, `owner` = 0
  - `mem_adr`, `mem_wd`, `cpu_rd`, `dbg_rd` = 0
  - Any in-flight access is abandoned with no ack.

## Timing
- Request sampled in IDLE at cycle 0. ISSUE is cycle 1, and `mem_adr` is valid from cycle 1.
- Write: `mem_we` high in cycle 1, ack in cycle 2.
- Read: WAIT spans cycles 2..1+MEMLAT; data captured at the end of cycle 1+MEMLAT; ack in cycle 2+MEMLAT.
- Throughput: the next grant is sampled in the IDLE cycle after ACK. A write occupies 3 cycles; a read occupies 3+MEMLAT cycles.
- The losing requester waits for the full current access plus the IDLE cycle. No request is dropped; with round-robin the maximum wait is one access.
- All outputs are registered, with no combinational path from a req input to any output.

## Structure
- **Package `mem_arb_pkg`:** state enum (IDLE/ISSUE/WAIT/ACK), port index constants `PORT_CPU` = 0 and `PORT_DBG` = 1, and the MEMLAT range bound.
- **Sub-module `rr_arb2`:** 2-way round-robin picker with inputs req[1:0] and last and output win. It is purely combinational; the pointer register stays in `mem_arbiter`.
- Wait counter: 3 bits.

## Test plan
- **Single core read:** MEMLAT=1, memory word 0x40 = 0xDEADBEEF, `cpu_req` read 0x40 at cycle 0 → `mem_adr` = 0x40 in cycle 1, `cpu_ack` in cycle 3, `cpu_rd` = 0xDEADBEEF, `dbg_ack` stays 0.
- **Single debug write:** `dbg_req` write 0x80 ← 0x12345678 → `mem_we` high only in cycle 1, `dbg_ack` in cycle 2, memory word 0x80 = 0x12345678, `cpu_rd` unchanged.
- **Simultaneous requests after reset:** both ports request reads, held until ack → core granted first (`owner` = 0). Debug is granted in the IDLE cycle after `cpu_ack` and acked MEMLAT+2 cycles later. A repeat tie then grants debug first.
- **Latency sweep:** MEMLAT = 1, 3, 7 with the read from scenario 1 → ack at cycle 3, 5, 9 respectively, and `mem_adr` stable throughout WAIT.
- **Reset mid-access:** assert reset during WAIT of a debug read → next cycle state is IDLE, `busy` = 0, `mem_we` = 0, `dbg_ack` never pulses, and `dbg_rd` = 0. A subsequent core read completes normally.
